int_ctrl: RTL and testbench

Vectored interrupt controller for the five-stage pipeline. It is the initiating end of the pipeline's `interrupt` flush line, the signal every stage register (IF/ID through MEM/WB) clears on. The block latches three edge-triggered request sources, arbitrates by priority, and supports nesting up to three levels on an internal EPC stack. It issues a one-cycle flush pulse with the handler address and supplies the return PC for `eret`.

---
 rtl/int_ctrl.sv | 124 ++++++++++++
 tb/tb_int_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge-latched requests, priority arbitration,
// three-deep EPC stack for nesting, one-cycle flush pulse and eret return PC.
module int_ctrl #(
  parameter logic [31:0] VEC0 = 32'h0000_0100,
  parameter logic [31:0] VEC1 = 32'h0000_0200,
  parameter logic [31:0] VEC2 = 32'h0000_0300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  irq_i,
  input  logic [2:0]  mask_i,
  input  logic        halt_i,
  input  logic [31:0] resume_pc_i,
  input  logic        eret_i,
  output logic        interrupt,
  output logic [31:0] vector_pc_o,
  output logic [31:0] epc_o,
  output logic [1:0]  level_o,
  output logic [2:0]  pending_o
);

  logic [2:0]  r_irq_q;
  logic        r_armed;
  logic [2:0]  r_pending;
  logic [1:0]  r_level;
  logic [1:0]  r_depth;
  logic [31:0] r_stk_pc  [3];
  logic [1:0]  r_stk_lvl [3];
  logic        r_interrupt;
  logic [31:0] r_vector;

  logic [2:0]  w_rise;
  logic [2:0]  w_lvl_ok;
  logic [2:0]  w_elig;
  logic [2:0]  w_sel_bit;
  logic [2:0]  w_clr;
  logic [1:0]  w_sel_lvl;
  logic [1:0]  w_pop_lvl;
  logic [31:0] w_sel_vec;
  logic [31:0] w_top_pc;
  logic        w_pop;
  logic        w_take;

  // Lines already high when reset releases count as seen, not as new edges.
  assign w_rise   = r_armed ? (irq_i & ~r_irq_q) : 3'b000;
  assign w_lvl_ok = {r_level < 2'd3, r_level < 2'd2, r_level < 2'd1};
  assign w_elig   = r_pending & mask_i & w_lvl_ok;
  assign w_pop    = eret_i && (r_level != 2'd0);
  assign w_take   = (|w_elig) && !halt_i && !eret_i && !r_interrupt;
  assign w_clr    = w_take ? w_sel_bit : 3'b000;

  always_comb begin
    w_sel_bit = 3'b000;
    w_sel_lvl = 2'd0;
    w_sel_vec = 32'h0;
    if (w_elig[2]) begin
      w_sel_bit = 3'b100;
      w_sel_lvl = 2'd3;
      w_sel_vec = VEC2;
    end else if (w_elig[1]) begin
      w_sel_bit = 3'b010;
      w_sel_lvl = 2'd2;
      w_sel_vec = VEC1;
    end else if (w_elig[0]) begin
      w_sel_bit = 3'b001;
      w_sel_lvl = 2'd1;
      w_sel_vec = VEC0;
    end
  end

  always_comb begin
    w_top_pc  = 32'h0;
    w_pop_lvl = 2'd0;
    case (r_depth)
      2'd1: begin w_top_pc = r_stk_pc[0]; w_pop_lvl = r_stk_lvl[0]; end
      2'd2: begin w_top_pc = r_stk_pc[1]; w_pop_lvl = r_stk_lvl[1]; end
      2'd3: begin w_top_pc = r_stk_pc[2]; w_pop_lvl = r_stk_lvl[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q     <= 3'b000;
      r_armed     <= 1'b0;
      r_pending   <= 3'b000;
      r_level     <= 2'd0;
      r_depth     <= 2'd0;
      r_interrupt <= 1'b0;
      r_vector    <= 32'h0;
      for (int i = 0; i < 3; i++) begin
        r_stk_pc[i]  <= 32'h0;
        r_stk_lvl[i] <= 2'd0;
      end
    end else begin
      r_irq_q     <= irq_i;
      r_armed     <= 1'b1;
      r_pending   <= (r_pending & ~w_clr) | w_rise;
      r_interrupt <= w_take;
      r_vector    <= w_take ? w_sel_vec : 32'h0;
      // eret and take are exclusive: w_take already excludes eret_i.
      if (w_pop) begin
        r_level <= w_pop_lvl;
        r_depth <= r_depth - 2'd1;
      end else if (w_take) begin
        r_level <= w_sel_lvl;
        r_depth <= r_depth + 2'd1;
        case (r_depth)
          2'd0: begin r_stk_pc[0] <= resume_pc_i; r_stk_lvl[0] <= r_level; end
          2'd1: begin r_stk_pc[1] <= resume_pc_i; r_stk_lvl[1] <= r_level; end
          2'd2: begin r_stk_pc[2] <= resume_pc_i; r_stk_lvl[2] <= r_level; end
          default: ;
        endcase
      end
    end
  end

  assign interrupt   = r_interrupt;
  assign vector_pc_o = r_vector;
  assign epc_o       = w_top_pc;
  assign level_o     = r_level;
  assign pending_o   = r_pending;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  irq_i;
  logic [2:0]  mask_i;
  logic        halt_i;
  logic [31:0] resume_pc_i;
  logic        eret_i;
  logic        interrupt;
  logic [31:0] vector_pc_o;
  logic [31:0] epc_o;
  logic [1:0]  level_o;
  logic [2:0]  pending_o;

  int n_tests = 0;
  int n_fail  = 0;

  int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .mask_i(mask_i), .halt_i(halt_i),
    .resume_pc_i(resume_pc_i), .eret_i(eret_i), .interrupt(interrupt),
    .vector_pc_o(vector_pc_o), .epc_o(epc_o), .level_o(level_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [2:0]  m_prev;
  logic        m_armed;
  logic [2:0]  m_pend;
  int          m_level;
  logic [31:0] m_stk_pc[$];
  int          m_stk_lvl[$];
  logic        m_int;
  logic [31:0] m_vec;

  typedef struct {
    logic [2:0]  irq;
    logic        eret;
    logic [31:0] pc;
    logic        ex_int;
    logic [31:0] ex_vec;
    logic [31:0] ex_epc;
    logic [1:0]  ex_lvl;
    logic [2:0]  ex_pend;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic ei, input logic [31:0] ev,
                         input logic [31:0] ee, input logic [1:0] el, input logic [2:0] ep);
    check({tag, ".interrupt"}, 32'(interrupt), 32'(ei));
    check({tag, ".vector"}, vector_pc_o, ev);
    check({tag, ".epc"}, epc_o, ee);
    check({tag, ".level"}, 32'(level_o), 32'(el));
    check({tag, ".pending"}, 32'(pending_o), 32'(ep));
  endtask

  function automatic logic [31:0] vec_of(input int k);
    case (k)
      0:       return 32'h100;
      1:       return 32'h200;
      default: return 32'h300;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = '0; m_armed = 1'b0; m_pend = '0; m_level = 0;
    m_stk_pc.delete(); m_stk_lvl.delete(); m_int = 1'b0; m_vec = '0;
  endtask

  task automatic model_step(input logic [2:0] irq, input logic [2:0] mask, input logic halt,
                            input logic [31:0] pc, input logic eret);
    logic [2:0] rise;
    int pick;
    logic take;
    rise = m_armed ? (irq & ~m_prev) : 3'b000;
    pick = -1;
    for (int k = 2; k >= 0; k--)
      if (pick < 0 && m_pend[k] && mask[k] && (k + 1 > m_level)) pick = k;
    take = (pick >= 0) && !halt && !eret && !m_int;
    m_int = take;
    m_vec = take ? vec_of(pick) : 32'h0;
    if (eret && m_level != 0) begin
      m_level = m_stk_lvl.pop_back();
      void'(m_stk_pc.pop_back());
    end else if (take) begin
      m_stk_pc.push_back(pc);
      m_stk_lvl.push_back(m_level);
      m_level = pick + 1;
      m_pend[pick] = 1'b0;
    end
    m_pend = m_pend | rise;
    m_prev = irq;
    m_armed = 1'b1;
  endtask

  task automatic compare_model();
    logic [31:0] ee;
    ee = (m_stk_pc.size() == 0) ? 32'h0 : m_stk_pc[$];
    chk_out("model", m_int, m_vec, ee, 2'(m_level), m_pend);
  endtask

  task automatic step(input logic [2:0] irq, input logic [2:0] mask, input logic halt,
                      input logic [31:0] pc, input logic eret);
    irq_i = irq; mask_i = mask; halt_i = halt; resume_pc_i = pc; eret_i = eret;
    @(posedge clk);
    model_step(irq, mask, halt, pc, eret);
    #1;
    compare_model();
  endtask

  initial begin
    tbl[0]  = '{3'b001, 1'b0, 32'h40, 1'b0, 32'h0,   32'h0,  2'd0, 3'b001};
    tbl[1]  = '{3'b000, 1'b0, 32'h40, 1'b1, 32'h100, 32'h40, 2'd1, 3'b000};
    tbl[2]  = '{3'b000, 1'b0, 32'h40, 1'b0, 32'h0,   32'h40, 2'd1, 3'b000};
    tbl[3]  = '{3'b000, 1'b1, 32'h40, 1'b0, 32'h0,   32'h0,  2'd0, 3'b000};
    tbl[4]  = '{3'b101, 1'b0, 32'h50, 1'b0, 32'h0,   32'h0,  2'd0, 3'b101};
    tbl[5]  = '{3'b000, 1'b0, 32'h50, 1'b1, 32'h300, 32'h50, 2'd3, 3'b001};
    tbl[6]  = '{3'b000, 1'b0, 32'h50, 1'b0, 32'h0,   32'h50, 2'd3, 3'b001};
    tbl[7]  = '{3'b000, 1'b1, 32'h60, 1'b0, 32'h0,   32'h0,  2'd0, 3'b001};
    tbl[8]  = '{3'b000, 1'b0, 32'h60, 1'b1, 32'h100, 32'h60, 2'd1, 3'b000};
    tbl[9]  = '{3'b000, 1'b0, 32'h60, 1'b0, 32'h0,   32'h60, 2'd1, 3'b000};
    tbl[10] = '{3'b000, 1'b1, 32'h60, 1'b0, 32'h0,   32'h0,  2'd0, 3'b000};

    // clock/reset
    rst_n = 1'b0; irq_i = '0; mask_i = '0; halt_i = 1'b0; resume_pc_i = '0; eret_i = 1'b0;
    model_reset();
    #2;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 2'd0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(3'b000, 3'b111, 1'b0, 32'h0, 1'b0);

    // single take and simultaneous sources
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].irq, 3'b111, 1'b0, tbl[i].pc, tbl[i].eret);
      chk_out($sformatf("tbl%0d", i), tbl[i].ex_int, tbl[i].ex_vec, tbl[i].ex_epc,
              tbl[i].ex_lvl, tbl[i].ex_pend);
    end

    // nesting, lower source blocked while higher in service
    step(3'b001, 3'b111, 1'b0, 32'h10, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h10, 1'b0);
    chk_out("nest0", 1'b1, 32'h100, 32'h10, 2'd1, 3'b000);
    step(3'b010, 3'b111, 1'b0, 32'h105, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h105, 1'b0);
    chk_out("nest1", 1'b1, 32'h200, 32'h105, 2'd2, 3'b000);
    step(3'b001, 3'b111, 1'b0, 32'h105, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h105, 1'b0);
    chk_out("blocked", 1'b0, 32'h0, 32'h105, 2'd2, 3'b001);
    step(3'b000, 3'b111, 1'b0, 32'h105, 1'b1);
    chk_out("eret1", 1'b0, 32'h0, 32'h10, 2'd1, 3'b001);
    step(3'b000, 3'b111, 1'b0, 32'h105, 1'b1);
    chk_out("eret2", 1'b0, 32'h0, 32'h0, 2'd0, 3'b001);
    step(3'b000, 3'b111, 1'b0, 32'h77, 1'b0);
    chk_out("late0", 1'b1, 32'h100, 32'h77, 2'd1, 3'b000);
    step(3'b000, 3'b111, 1'b0, 32'h77, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h77, 1'b1);

    // halt holds the request
    step(3'b010, 3'b111, 1'b1, 32'h20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 3'b111, 1'b1, 32'h20, 1'b0);
      chk_out("halt", 1'b0, 32'h0, 32'h0, 2'd0, 3'b010);
    end
    step(3'b000, 3'b111, 1'b0, 32'h20, 1'b0);
    chk_out("halt_rel", 1'b1, 32'h200, 32'h20, 2'd2, 3'b000);
    step(3'b000, 3'b111, 1'b0, 32'h20, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h20, 1'b1);

    // mask holds the request
    step(3'b010, 3'b000, 1'b0, 32'h30, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 3'b000, 1'b0, 32'h30, 1'b0);
      chk_out("mask", 1'b0, 32'h0, 32'h0, 2'd0, 3'b010);
    end
    step(3'b000, 3'b111, 1'b0, 32'h30, 1'b0);
    chk_out("unmask", 1'b1, 32'h200, 32'h30, 2'd2, 3'b000);
    step(3'b000, 3'b111, 1'b0, 32'h30, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h30, 1'b1);

    // eret against an eligible request: eret first, take next cycle
    step(3'b001, 3'b111, 1'b0, 32'h44, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h44, 1'b0);
    step(3'b010, 3'b111, 1'b0, 32'h48, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h48, 1'b1);
    chk_out("eret_win", 1'b0, 32'h0, 32'h0, 2'd0, 3'b010);
    step(3'b000, 3'b111, 1'b0, 32'h4c, 1'b0);
    chk_out("after_eret", 1'b1, 32'h200, 32'h4c, 2'd2, 3'b000);
    step(3'b000, 3'b111, 1'b0, 32'h4c, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h4c, 1'b1);

    // reset mid-service with a pending request, irq held high across reset
    step(3'b001, 3'b111, 1'b0, 32'h80, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h80, 1'b0);
    step(3'b010, 3'b111, 1'b0, 32'h84, 1'b0);
    step(3'b000, 3'b111, 1'b0, 32'h84, 1'b0);
    step(3'b001, 3'b111, 1'b0, 32'h88, 1'b0);
    chk_out("pre_rst", 1'b0, 32'h0, 32'h84, 2'd2, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 32'h0, 32'h0, 2'd0, 3'b000);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(3'b001, 3'b111, 1'b0, 32'h90, 1'b0);
      check("no_spurious", 32'(interrupt), 32'h0);
    end
    step(3'b000, 3'b111, 1'b0, 32'h90, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r_irq, r_mask;
      r_irq  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      r_mask = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      step(r_irq, r_mask, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
